// File: rtl/mux_pattern_gen_if.sv
// Control and pattern bus between the stimulus generator and its consumers.
// master: the pattern generator (takes controls, drives pattern outputs).
// slave:  the board/controller side (drives controls, observes pattern outputs).
interface mux_pattern_gen_if;
    logic       start;
    logic       pause;
    logic       step;
    logic       clear;
    logic       x;
    logic       y;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [5:0] pat;
    logic       tick;
    logic       busy;
    logic       done;

    modport master (
        input  start, pause, step, clear,
        output x, y, a, b, c, d, pat, tick, busy, done
    );

    modport slave (
        output start, pause, step, clear,
        input  x, y, a, b, c, d, pat, tick, busy, done
    );
endinterface

// File: rtl/mux_pattern_gen.sv
// Six-bit stimulus sweep for the lab multiplexer stage. Walks the 64 input
// combinations in binary order (x fastest, d slowest) at a prescaled rate,
// with run / pause / single-step / clear controls.
module mux_pattern_gen #(
    parameter int unsigned DIV  = 10,   // clocks per pattern step in RUN (1..65535)
    parameter bit          LOOP = 1'b0  // 1: wrap 63->0 and keep running
) (
    input logic              clk,
    input logic              rst_n,
    mux_pattern_gen_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [5:0]  pat_q, pat_d;
    logic        tick_q, tick_d;
    logic        busy_q, done_q;

    // State, prescaler, pattern and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            pat_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pat_q   <= pat_d;
            tick_q  <= tick_d;
            busy_q  <= (state_d == RUN) || (state_d == PAUSE);
            done_q  <= (state_d == DONE);
        end
    end

    // Next-state logic; control priority is clear > pause > start > step.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pat_d   = pat_q;
        tick_d  = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            presc_d = '0;
            pat_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.pause) begin
                        // pause outranks start/step and does nothing here
                    end else if (bus.start) begin
                        state_d = RUN;
                        presc_d = '0;
                    end else if (bus.step) begin
                        pat_d  = pat_q + 6'd1;
                        tick_d = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        // freeze: prescaler does not count on the pausing edge
                        state_d = PAUSE;
                    end else if (presc_q == DIV_M1) begin
                        presc_d = '0;
                        if (pat_q == 6'd63) begin
                            if (LOOP) begin
                                pat_d  = '0;
                                tick_d = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            pat_d  = pat_q + 6'd1;
                            tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                PAUSE: begin
                    if (bus.pause) begin
                        // remain frozen
                    end else if (bus.start) begin
                        // resume with the held prescaler value
                        state_d = RUN;
                    end else if (bus.step) begin
                        pat_d  = pat_q + 6'd1;
                        tick_d = 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        presc_d = '0;
                        pat_d   = '0;
                        tick_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.pat  = pat_q;
    assign bus.x    = pat_q[0];
    assign bus.y    = pat_q[1];
    assign bus.a    = pat_q[2];
    assign bus.b    = pat_q[3];
    assign bus.c    = pat_q[4];
    assign bus.d    = pat_q[5];
    assign bus.tick = tick_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mux_pattern_gen.sv
// Bench for mux_pattern_gen: three instances (sweep, loop, control tests)
// checked every cycle against a phase-based reference model, plus
// hand-computed expectations at the interesting points.
module tb_mux_pattern_gen;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    // Reference: position within the sweep measured in clocks (pat*DIV + prescaler).
    typedef struct {
        int mode;
        int phase;
        bit tick;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;
    int ticks0 = 0;
    int ticks_all = 0;

    mdl_t m0 = '{M_IDLE, 0, 1'b0};
    mdl_t m1 = '{M_IDLE, 0, 1'b0};
    mdl_t m2 = '{M_IDLE, 0, 1'b0};

    mux_pattern_gen_if if0();
    mux_pattern_gen_if if1();
    mux_pattern_gen_if if2();

    mux_pattern_gen #(.DIV(10), .LOOP(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_pattern_gen #(.DIV(1),  .LOOP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_pattern_gen #(.DIV(4),  .LOOP(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_next(mdl_t s, int div, bit loop, bit st, bit pa, bit sp, bit cl);
        mdl_t n;
        n = s;
        n.tick = 1'b0;
        if (cl) begin
            n.mode  = M_IDLE;
            n.phase = 0;
        end else begin
            case (s.mode)
                M_IDLE, M_PAUSE: begin
                    if (!pa) begin
                        if (st) n.mode = M_RUN;
                        else if (sp) begin
                            n.phase = (s.phase + div) % (64 * div);
                            n.tick  = 1'b1;
                        end
                    end
                end
                M_RUN: begin
                    if (pa) n.mode = M_PAUSE;
                    else begin
                        n.phase = s.phase + 1;
                        if (n.phase == 64 * div) begin
                            if (loop) begin
                                n.phase = 0;
                                n.tick  = 1'b1;
                            end else begin
                                n.mode  = M_DONE;
                                n.phase = 63 * div;
                            end
                        end else if (n.phase % div == 0) begin
                            n.tick = 1'b1;
                        end
                    end
                end
                default: begin
                    if (st) begin
                        n.mode  = M_RUN;
                        n.phase = 0;
                        n.tick  = 1'b1;
                    end
                end
            endcase
        end
        return n;
    endfunction

    function automatic logic [14:0] mdl_out(mdl_t s, int div);
        int p;
        p = s.phase / div;
        return {6'(p), 6'(p), s.tick, (s.mode == M_RUN) || (s.mode == M_PAUSE), s.mode == M_DONE};
    endfunction

    // Per-cycle compare of all three instances against the reference.
    always @(posedge clk) begin
        if (!rst_n) begin
            m0 = '{M_IDLE, 0, 1'b0};
            m1 = '{M_IDLE, 0, 1'b0};
            m2 = '{M_IDLE, 0, 1'b0};
        end else begin
            m0 = mdl_next(m0, 10, 1'b0, if0.start, if0.pause, if0.step, if0.clear);
            m1 = mdl_next(m1, 1,  1'b1, if1.start, if1.pause, if1.step, if1.clear);
            m2 = mdl_next(m2, 4,  1'b0, if2.start, if2.pause, if2.step, if2.clear);
        end
        #1;
        chk("u0_cycle", {17'd0, if0.pat, if0.d, if0.c, if0.b, if0.a, if0.y, if0.x, if0.tick, if0.busy, if0.done},
            {17'd0, mdl_out(m0, 10)});
        chk("u1_cycle", {17'd0, if1.pat, if1.d, if1.c, if1.b, if1.a, if1.y, if1.x, if1.tick, if1.busy, if1.done},
            {17'd0, mdl_out(m1, 1)});
        chk("u2_cycle", {17'd0, if2.pat, if2.d, if2.c, if2.b, if2.a, if2.y, if2.x, if2.tick, if2.busy, if2.done},
            {17'd0, mdl_out(m2, 4)});
        if (if0.tick === 1'b1) ticks0++;
        if (if0.tick === 1'b1 || if1.tick === 1'b1 || if2.tick === 1'b1) ticks_all++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full LOOP=0 sweep at DIV=10.
    task automatic run_sweep;
        int base;
        if0.start = 1'b1;
        cyc(1);
        if0.start = 1'b0;
        base = ticks0;
        chk("sweep_busy_at_start", 32'(if0.busy), 32'd1);
        cyc(320);
        chk("sweep_pat_mid", 32'(if0.pat), 32'd32);
        chk("sweep_d_mid", 32'(if0.d), 32'd1);
        chk("sweep_x_mid", 32'(if0.x), 32'd0);
        cyc(319);
        chk("sweep_pat_last", 32'(if0.pat), 32'd63);
        chk("sweep_not_done_yet", 32'(if0.done), 32'd0);
        cyc(1);
        chk("sweep_done", 32'(if0.done), 32'd1);
        chk("sweep_busy_end", 32'(if0.busy), 32'd0);
        chk("sweep_pat_end", 32'(if0.pat), 32'd63);
        chk("sweep_tick_count", 32'(ticks0 - base), 32'd63);
    endtask

    // LOOP=1 at DIV=1 with start held.
    task automatic run_loop;
        if1.start = 1'b1;
        cyc(1);
        chk("loop_pat_start", 32'(if1.pat), 32'd0);
        cyc(639);
        chk("loop_pat_639", 32'(if1.pat), 32'd63);
        chk("loop_tick_639", 32'(if1.tick), 32'd1);
        cyc(1);
        chk("loop_wrap_pat", 32'(if1.pat), 32'd0);
        chk("loop_wrap_tick", 32'(if1.tick), 32'd1);
        chk("loop_done_low", 32'(if1.done), 32'd0);
    endtask

    // Pause/resume, stepping, DONE behaviour and control priority at DIV=4.
    task automatic run_ctrl;
        if2.start = 1'b1;
        cyc(1);
        if2.start = 1'b0;
        cyc(6);
        chk("pause_pre_pat", 32'(if2.pat), 32'd1);
        if2.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("pause_frozen_pat", 32'(if2.pat), 32'd1);
        end
        chk("pause_busy", 32'(if2.busy), 32'd1);
        if2.pause = 1'b0;
        if2.start = 1'b1;
        cyc(1);
        if2.start = 1'b0;
        chk("resume_pat_m", 32'(if2.pat), 32'd1);
        cyc(1);
        chk("resume_pat_m1", 32'(if2.pat), 32'd1);
        cyc(1);
        chk("resume_pat_m2", 32'(if2.pat), 32'd2);
        chk("resume_tick_m2", 32'(if2.tick), 32'd1);

        if2.clear = 1'b1;
        cyc(1);
        if2.clear = 1'b0;
        chk("clear_pat", 32'(if2.pat), 32'd0);
        chk("clear_busy", 32'(if2.busy), 32'd0);

        for (int i = 0; i < 3; i++) begin
            if2.step = 1'b1;
            cyc(1);
            chk("step_tick_hi", 32'(if2.tick), 32'd1);
            if2.step = 1'b0;
            cyc(1);
            chk("step_tick_lo", 32'(if2.tick), 32'd0);
        end
        chk("step_pat3", 32'(if2.pat), 32'd3);

        if2.start = 1'b1;
        cyc(1);
        if2.start = 1'b0;
        if2.pause = 1'b1;
        cyc(1);
        if2.pause = 1'b0;
        chk("pause_entry_pat", 32'(if2.pat), 32'd3);
        if2.step = 1'b1;
        cyc(60);
        if2.step = 1'b0;
        chk("held_step_pat", 32'(if2.pat), 32'd63);
        if2.step = 1'b1;
        cyc(1);
        if2.step = 1'b0;
        chk("pause_wrap_pat", 32'(if2.pat), 32'd0);
        chk("pause_wrap_tick", 32'(if2.tick), 32'd1);
        chk("pause_wrap_busy", 32'(if2.busy), 32'd1);

        if2.start = 1'b1;
        cyc(1);
        if2.start = 1'b0;
        cyc(256);
        chk("ctrl_done", 32'(if2.done), 32'd1);
        if2.step = 1'b1;
        cyc(1);
        if2.step = 1'b0;
        chk("done_step_pat", 32'(if2.pat), 32'd63);
        chk("done_step_tick", 32'(if2.tick), 32'd0);

        if2.start = 1'b1;
        cyc(1);
        if2.start = 1'b0;
        chk("restart_pat", 32'(if2.pat), 32'd0);
        chk("restart_tick", 32'(if2.tick), 32'd1);
        chk("restart_busy", 32'(if2.busy), 32'd1);
        cyc(80);
        chk("prio_pre_pat", 32'(if2.pat), 32'd20);
        if2.clear = 1'b1;
        if2.pause = 1'b1;
        if2.start = 1'b1;
        cyc(1);
        if2.clear = 1'b0;
        if2.pause = 1'b0;
        if2.start = 1'b0;
        chk("prio_pat", 32'(if2.pat), 32'd0);
        chk("prio_busy", 32'(if2.busy), 32'd0);
        chk("prio_tick", 32'(if2.tick), 32'd0);
    endtask

    initial begin
        {if0.start, if0.pause, if0.step, if0.clear} = '0;
        {if1.start, if1.pause, if1.step, if1.clear} = '0;
        {if2.start, if2.pause, if2.step, if2.clear} = '0;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        chk("idle_pat", 32'(if0.pat), 32'd0);
        chk("idle_busy", 32'(if0.busy), 32'd0);
        chk("idle_done", 32'(if0.done), 32'd0);
        chk("idle_no_ticks", 32'(ticks_all), 32'd0);

        fork
            run_sweep();
            run_loop();
            run_ctrl();
        join

        if2.start = 1'b1;
        cyc(1);
        if2.start = 1'b0;
        cyc(7);
        chk("async_pre_pat", 32'(if2.pat), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_u2_pat", 32'(if2.pat), 32'd0);
        chk("async_u2_busy", 32'(if2.busy), 32'd0);
        chk("async_u1_tick", 32'(if1.tick), 32'd0);
        chk("async_u1_pat", 32'(if1.pat), 32'd0);
        chk("async_u0_done", 32'(if0.done), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
